axis_stream_tid_arbiter: RTL and testbench

//  Packet-granular arbiter that merges NUM_SOURCES AXI-Stream producers onto the single

---
 rtl/axis_stream_tid_arbiter.sv | 111 +++++++++++
 tb/tb_axis_stream_tid_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_tid_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SOURCES AXI-Stream producers, m_tid = source index.
// Latency: 1-cycle grant bubble per packet, then 0-cycle data passthrough; backpressure: m_tready routed to granted s_tready only.
// Option: define STREAM_ARB_WEIGHT_PRIORITY_EN to give source 0 (weights) strict priority at every arbitration.
module axis_stream_tid_arbiter #(
  parameter int DATA_WIDTH  = 64,
  parameter int NUM_SOURCES = 4,
  parameter int TID_WIDTH   = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SOURCES-1:0]            s_tvalid,
  input  logic [NUM_SOURCES-1:0]            s_tlast,
  output logic [NUM_SOURCES-1:0]            s_tready,
  input  logic [NUM_SOURCES-1:0]            i_src_enable,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic                              m_tvalid,
  output logic                              m_tlast,
  output logic [TID_WIDTH-1:0]              m_tid,
  input  logic                              m_tready,
  output logic [NUM_SOURCES-1:0]            o_grant,
  output logic                              o_busy,
  output logic [CNT_WIDTH-1:0]              o_beat_count
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state;
  logic [NUM_SOURCES-1:0] grant;
  logic [TID_WIDTH-1:0]   tid;
  logic [TID_WIDTH-1:0]   last_grant;
  logic                   busy;
  logic [CNT_WIDTH-1:0]   beat_count;

  logic [NUM_SOURCES-1:0] req;
  logic [TID_WIDTH-1:0]   pick;
  logic                   pick_vld;
  logic                   locked;
  logic                   accept;

  // Search starts just after the previous winner so nobody wins twice while others wait.
  always_comb begin
    int idx;
    idx      = 0;
    req      = s_tvalid & i_src_enable;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NUM_SOURCES; k++) begin
      idx = (int'(last_grant) + k) % NUM_SOURCES;
      if (!pick_vld && req[idx]) begin
        pick     = TID_WIDTH'(idx);
        pick_vld = 1'b1;
      end
    end
`ifdef STREAM_ARB_WEIGHT_PRIORITY_EN
    if (req[0]) begin
      pick     = '0;
      pick_vld = 1'b1;
    end
`else
`endif
  end

  assign locked       = (state == LOCKED);
  assign m_tdata      = locked ? s_tdata[tid*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign m_tvalid     = locked & s_tvalid[tid];
  assign m_tlast      = locked & s_tlast[tid];
  assign s_tready     = grant & {NUM_SOURCES{m_tready}};
  assign m_tid        = tid;
  assign o_grant      = grant;
  assign o_busy       = busy;
  assign o_beat_count = beat_count;
  assign accept       = m_tvalid & m_tready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= '0;
      tid        <= '0;
      busy       <= 1'b0;
      beat_count <= '0;
      last_grant <= TID_WIDTH'(NUM_SOURCES - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state      <= LOCKED;
            grant      <= NUM_SOURCES'(1) << pick;
            tid        <= pick;
            busy       <= 1'b1;
            beat_count <= '0;
          end
        end
        LOCKED: begin
          if (accept) begin
            if (beat_count != '1) beat_count <= beat_count + CNT_WIDTH'(1);
            if (m_tlast) begin
              state      <= IDLE;
              last_grant <= tid;
              grant      <= '0;
              tid        <= '0;
              busy       <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_stream_tid_arbiter.sv
// Directed bench for axis_stream_tid_arbiter: per-source packet generators, completion-order log.
module tb_axis_stream_tid_arbiter;
  localparam int DW = 64;
  localparam int NS = 4;
  localparam int TW = 2;
  localparam int CW = 16;

  logic             clk = 1'b0;
  logic             resetn;
  logic [NS*DW-1:0] s_tdata;
  logic [NS-1:0]    s_tvalid, s_tlast, s_tready, i_src_enable, o_grant;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid, m_tlast, m_tready, o_busy;
  logic [TW-1:0]    m_tid;
  logic [CW-1:0]    o_beat_count;

  axis_stream_tid_arbiter #(.DATA_WIDTH(DW), .NUM_SOURCES(NS), .TID_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .i_src_enable(i_src_enable), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tlast(m_tlast), .m_tid(m_tid), .m_tready(m_tready), .o_grant(o_grant), .o_busy(o_busy),
    .o_beat_count(o_beat_count));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Source generators: len beats per packet, left packets outstanding.
  int len[NS], left[NS], pkt[NS], beat[NS];
  logic [NS-1:0] hs;
  int order[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_dat(input int s, input int p, input int b);
    return 64'hA500_0000_0000_0000 | (64'(s) << 16) | (64'(p) << 8) | 64'(b);
  endfunction

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      s_tvalid[i] = (left[i] > 0);
      s_tlast[i]  = (left[i] > 0) && (beat[i] == len[i] - 1);
      s_tdata[i*DW +: DW] = exp_dat(i, pkt[i], beat[i]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready && m_tlast) order.push_back(int'(m_tid));
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (hs[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          pkt[i]++;
          left[i]--;
        end else begin
          beat[i]++;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NS; i++) begin
      len[i] = 1; left[i] = 0; pkt[i] = 0; beat[i] = 0;
    end
    order.delete();
    drive();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    m_tready = 1'b1;
    i_src_enable = '1;
    clear_srcs();
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic queue_pkts(input int s, input int l, input int n);
    len[s] = l; left[s] = n; pkt[s] = 0; beat[s] = 0;
    drive();
    #1;
  endtask

  task automatic run_done(input string tag, input int budget);
    int c;
    c = 0;
    while ((left[0] + left[1] + left[2] + left[3]) > 0 && c < budget) begin
      tick();
      c++;
    end
    if (c >= budget) chk({tag, "_timeout"}, 64'(c), 64'(0));
    tick();
  endtask

  task automatic chk_order(input string tag, input int exp_q[$]);
    chk({tag, "_npkts"}, 64'(order.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < order.size(); i++)
      chk($sformatf("%s_order%0d", tag, i), 64'(order[i]), 64'(exp_q[i]));
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_tvalid", 64'(m_tvalid), 0);
    chk("rst_grant", 64'(o_grant), 0);
    chk("rst_tid", 64'(m_tid), 0);
    chk("rst_tready", 64'(s_tready), 0);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_count", 64'(o_beat_count), 0);

    // 1: single 4-beat packet from src1
    queue_pkts(1, 4, 1);
    chk("t1_idle_tvalid", 64'(m_tvalid), 0);
    chk("t1_idle_tready", 64'(s_tready), 0);
    tick();
    chk("t1_tid", 64'(m_tid), 1);
    chk("t1_grant", 64'(o_grant), 64'h2);
    chk("t1_busy", 64'(o_busy), 1);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("t1_tvalid%0d", b), 64'(m_tvalid), 1);
      chk($sformatf("t1_tdata%0d", b), m_tdata, exp_dat(1, 0, b));
      chk($sformatf("t1_tlast%0d", b), 64'(m_tlast), 64'(b == 3));
      tick();
    end
    chk("t1_busy_after", 64'(o_busy), 0);
    chk("t1_count", 64'(o_beat_count), 4);
    tick();
    chk("t1_count_hold", 64'(o_beat_count), 4);
    chk("t1_grant_idle", 64'(o_grant), 0);

    // 2: src0, src2, src3 competing from reset
    do_reset();
    queue_pkts(0, 2, 2);
    queue_pkts(2, 2, 2);
    queue_pkts(3, 2, 2);
    run_done("t2", 60);
    chk_order("t2", '{0, 2, 3, 0, 2, 3});
    chk("t2_count", 64'(o_beat_count), 2);

    // 3: backpressure on beats 2-3 of src1 while src2 waits
    do_reset();
    queue_pkts(1, 4, 1);
    queue_pkts(2, 1, 1);
    tick();
    chk("t3_tid", 64'(m_tid), 1);
    tick();
    m_tready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("t3_tready%0d", c), 64'(s_tready), 0);
      chk($sformatf("t3_tdata%0d", c), m_tdata, exp_dat(1, 0, 1));
      chk($sformatf("t3_grant%0d", c), 64'(o_grant), 64'h2);
      tick();
    end
    m_tready = 1'b1;
    #1;
    chk("t3_tready_rel", 64'(s_tready), 64'h2);
    run_done("t3", 40);
    chk_order("t3", '{1, 2});

    // 4: enable gating, then enable dropped mid-packet
    do_reset();
    i_src_enable[2] = 1'b0;
    queue_pkts(2, 3, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("t4_tvalid%0d", c), 64'(m_tvalid), 0);
      chk($sformatf("t4_grant%0d", c), 64'(o_grant), 0);
    end
    i_src_enable[2] = 1'b1;
    tick();
    chk("t4_tid", 64'(m_tid), 2);
    tick();
    i_src_enable[2] = 1'b0;
    run_done("t4", 20);
    chk_order("t4", '{2});
    chk("t4_count", 64'(o_beat_count), 3);

    // 5: reset mid-packet abandons the packet; src0 wins afterwards
    do_reset();
    queue_pkts(3, 5, 1);
    tick();
    tick();
    chk("t5_mid_tid", 64'(m_tid), 3);
    chk("t5_mid_tdata", m_tdata, exp_dat(3, 0, 1));
    resetn = 1'b0;
    tick();
    chk("t5_tvalid", 64'(m_tvalid), 0);
    chk("t5_grant", 64'(o_grant), 0);
    chk("t5_busy", 64'(o_busy), 0);
    chk("t5_tid", 64'(m_tid), 0);
    chk("t5_tready", 64'(s_tready), 0);
    chk("t5_count", 64'(o_beat_count), 0);
    clear_srcs();
    resetn = 1'b1;
    queue_pkts(3, 2, 1);
    queue_pkts(0, 2, 1);
    run_done("t5", 30);
    chk_order("t5", '{0, 3});

    // 6: src0 and src1 continuously requesting
    do_reset();
    queue_pkts(0, 2, 3);
    queue_pkts(1, 2, 3);
    run_done("t6", 60);
`ifdef STREAM_ARB_WEIGHT_PRIORITY_EN
    chk_order("t6", '{0, 0, 0, 1, 1, 1});
`else
    chk_order("t6", '{0, 1, 0, 1, 0, 1});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
